// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared types and helpers for the memory responder: FSM state
//            and grant encodings, data word width, line-index slicing.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I_RD = 2'd1,
        GNT_D_RD = 2'd2,
        GNT_D_WR = 2'd3
    } grant_t;

    // Word index of the first word of the line containing byte_addr. Byte
    // offset and word-in-line bits are dropped; bits above the backing store
    // depth are discarded, so such addresses alias onto the store.
    function automatic logic [31:0] line_base_word(
        input logic [63:0] byte_addr,
        input int          mem_words_log2,
        input int          line_words_log2
    );
        logic [63:0] w;
        w = byte_addr >> 2;
        w = w & ((64'd1 << mem_words_log2) - 64'd1);
        w = w & ~((64'd1 << line_words_log2) - 64'd1);
        return w[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/response bundle between the caches (master) and the
//            memory responder (slave): I-cache read, D-cache read and
//            D-cache writeback channels.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
    parameter int ADDR_W = 26
) ();
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_addr_valid;
    logic              i_rd_addr_ready;
    logic [31:0]       i_rd_data;
    logic              i_rd_data_valid;

    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_addr_valid;
    logic              d_rd_addr_ready;
    logic [31:0]       d_rd_data;
    logic              d_rd_data_valid;

    logic [ADDR_W-1:0] d_wr_addr;
    logic              d_wr_addr_valid;
    logic              d_wr_addr_ready;
    logic [31:0]       d_wr_data;
    logic              d_wr_data_valid;
    logic              d_wr_data_ready;

    modport master (
        output i_rd_addr, i_rd_addr_valid,
        input  i_rd_addr_ready, i_rd_data, i_rd_data_valid,
        output d_rd_addr, d_rd_addr_valid,
        input  d_rd_addr_ready, d_rd_data, d_rd_data_valid,
        output d_wr_addr, d_wr_addr_valid, d_wr_data, d_wr_data_valid,
        input  d_wr_addr_ready, d_wr_data_ready
    );

    modport slave (
        input  i_rd_addr, i_rd_addr_valid,
        output i_rd_addr_ready, i_rd_data, i_rd_data_valid,
        input  d_rd_addr, d_rd_addr_valid,
        output d_rd_addr_ready, d_rd_data, d_rd_data_valid,
        input  d_wr_addr, d_wr_addr_valid, d_wr_data, d_wr_data_valid,
        output d_wr_addr_ready, d_wr_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_resp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_arbiter
// Purpose  : Combinational grant among the three request channels while the
//            responder is idle. Writeback always wins. With
//            MEM_RESPONDER_RR_ARB_EN defined the two read channels alternate
//            using a last-served pointer; otherwise D-read beats I-read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_arbiter
    import mem_responder_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic enable,
    input  wire logic i_rd_valid,
    input  wire logic d_rd_valid,
    input  wire logic d_wr_valid,
    output grant_t    grant
);

`ifdef MEM_RESPONDER_RR_ARB_EN
    // High when the D-cache read channel is next in line among the readers.
    logic r_prefer_d;

    // Track which reader was served last; every read grant is an acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prefer_d <= 1'b1;
        end else if (enable && (grant == GNT_I_RD || grant == GNT_D_RD)) begin
            r_prefer_d <= (grant == GNT_I_RD);
        end
    end

    // Writeback first, then round-robin between the two readers.
    always_comb begin
        grant = GNT_NONE;
        if (enable) begin
            if (d_wr_valid)                    grant = GNT_D_WR;
            else if (d_rd_valid && i_rd_valid) grant = r_prefer_d ? GNT_D_RD : GNT_I_RD;
            else if (d_rd_valid)               grant = GNT_D_RD;
            else if (i_rd_valid)               grant = GNT_I_RD;
        end
    end
`else
    // Fixed priority needs no state, so clock and reset have no load here.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    // Fixed priority: writeback, then D-read, then I-read.
    always_comb begin
        grant = GNT_NONE;
        if (enable) begin
            if (d_wr_valid)      grant = GNT_D_WR;
            else if (d_rd_valid) grant = GNT_D_RD;
            else if (i_rd_valid) grant = GNT_I_RD;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Responder for I-cache line reads, D-cache line reads and D-cache
//            line writebacks. One request is served at a time against a
//            word-wide backing store; reads return a fixed-latency burst,
//            writes accept one word per valid beat.
//            Optional: MEM_RESPONDER_RR_ARB_EN selects round-robin between
//            the two read channels (see mem_resp_arbiter).
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W          = 26,
    parameter int MEM_WORDS_LOG2  = 14,
    parameter int LINE_WORDS_LOG2 = 2,
    parameter int LATENCY         = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_responder_if.slave bus
);

    localparam int                  MEM_WORDS  = 1 << MEM_WORDS_LOG2;
    localparam int                  BEAT_W     = LINE_WORDS_LOG2 + 1;
    localparam logic [BEAT_W-1:0]   LINE_WORDS = BEAT_W'(1 << LINE_WORDS_LOG2);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'((1 << LINE_WORDS_LOG2) - 1);
    localparam logic [3:0]          LAT_LOAD   = 4'(LATENCY - 1);

    state_t                    r_state;
    grant_t                    r_gnt;
    grant_t                    w_gnt;
    logic                      w_idle;
    logic [MEM_WORDS_LOG2-1:0] r_line;
    logic [BEAT_W-1:0]         r_beat;
    logic [3:0]                r_lat;
    logic                      r_wr_ready;
    logic [WORD_W-1:0]         r_i_data;
    logic [WORD_W-1:0]         r_d_data;
    logic                      r_i_valid;
    logic                      r_d_valid;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic                      w_present;
    logic                      w_wr_fire;
    logic [WORD_W-1:0]         mem [MEM_WORDS];

    assign w_idle = (r_state == IDLE);

    mem_resp_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .enable     (w_idle),
        .i_rd_valid (bus.i_rd_addr_valid),
        .d_rd_valid (bus.d_rd_addr_valid),
        .d_wr_valid (bus.d_wr_addr_valid),
        .grant      (w_gnt)
    );

    // The grant is only non-NONE in IDLE, so ready doubles as acceptance.
    assign bus.i_rd_addr_ready = (w_gnt == GNT_I_RD);
    assign bus.d_rd_addr_ready = (w_gnt == GNT_D_RD);
    assign bus.d_wr_addr_ready = (w_gnt == GNT_D_WR);
    assign bus.d_wr_data_ready = r_wr_ready;
    assign bus.i_rd_data       = r_i_data;
    assign bus.i_rd_data_valid = r_i_valid;
    assign bus.d_rd_data       = r_d_data;
    assign bus.d_rd_data_valid = r_d_valid;

    assign w_idx     = r_line + MEM_WORDS_LOG2'(r_beat);
    assign w_wr_fire = (r_state == WR_BURST) && bus.d_wr_data_valid;
    // A read word is launched on the last wait cycle and on every burst cycle
    // until the beat counter has walked past the end of the line.
    assign w_present = ((r_state == RD_WAIT) && (r_lat == 4'd0)) ||
                       ((r_state == RD_BURST) && (r_beat != LINE_WORDS));

    // Sequencing of a single transaction: grant capture, latency, beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= GNT_NONE;
            r_line     <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt  <= w_gnt;
                    r_beat <= '0;
                    if (w_gnt == GNT_D_WR) begin
                        r_state    <= WR_BURST;
                        r_wr_ready <= 1'b1;
                        r_line     <= MEM_WORDS_LOG2'(line_base_word(64'(bus.d_wr_addr),
                                                     MEM_WORDS_LOG2, LINE_WORDS_LOG2));
                    end else if (w_gnt == GNT_D_RD) begin
                        r_state <= RD_WAIT;
                        r_lat   <= LAT_LOAD;
                        r_line  <= MEM_WORDS_LOG2'(line_base_word(64'(bus.d_rd_addr),
                                                  MEM_WORDS_LOG2, LINE_WORDS_LOG2));
                    end else if (w_gnt == GNT_I_RD) begin
                        r_state <= RD_WAIT;
                        r_lat   <= LAT_LOAD;
                        r_line  <= MEM_WORDS_LOG2'(line_base_word(64'(bus.i_rd_addr),
                                                  MEM_WORDS_LOG2, LINE_WORDS_LOG2));
                    end
                end
                RD_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_state <= RD_BURST;
                        r_beat  <= r_beat + BEAT_W'(1);
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                RD_BURST: begin
                    if (r_beat == LINE_WORDS) begin
                        r_state <= IDLE;
                        r_gnt   <= GNT_NONE;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                WR_BURST: begin
                    if (bus.d_wr_data_valid) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state    <= IDLE;
                            r_gnt      <= GNT_NONE;
                            r_wr_ready <= 1'b0;
                            r_beat     <= '0;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered read data; the channel that is not being served stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_data  <= '0;
            r_d_data  <= '0;
        end else begin
            r_i_valid <= w_present && (r_gnt == GNT_I_RD);
            r_d_valid <= w_present && (r_gnt == GNT_D_RD);
            r_i_data  <= (w_present && (r_gnt == GNT_I_RD)) ? mem[w_idx] : '0;
            r_d_data  <= (w_present && (r_gnt == GNT_D_RD)) ? mem[w_idx] : '0;
        end
    end

    // Backing store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem[w_idx] <= bus.d_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (default arbitration).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(26)) bus ();

    mem_responder #(
        .ADDR_W          (26),
        .MEM_WORDS_LOG2  (14),
        .LINE_WORDS_LOG2 (2),
        .LATENCY         (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic [3:0][31:0] line_t;

    typedef struct {
        int          op;      // 0 write, 1 D-read, 2 I-read
        logic [25:0] addr;
        bit          gapped;
        line_t       words;   // write data or expected read data
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic line_t mk4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        line_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic logic [2:0] readies();
        return {bus.i_rd_addr_ready, bus.d_rd_addr_ready, bus.d_wr_addr_ready};
    endfunction

    function automatic logic [95:0] all_outs();
        return {26'd0, bus.i_rd_data_valid, bus.i_rd_data, bus.d_rd_data_valid,
                bus.d_rd_data, readies(), bus.d_wr_data_ready};
    endfunction

    function automatic logic ready_of(input int ch);
        case (ch)
            0:       return bus.i_rd_addr_ready;
            1:       return bus.d_rd_addr_ready;
            default: return bus.d_wr_addr_ready;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [25:0] addr, input logic v);
        case (ch)
            0: begin bus.i_rd_addr = addr; bus.i_rd_addr_valid = v; end
            1: begin bus.d_rd_addr = addr; bus.d_rd_addr_valid = v; end
            default: begin bus.d_wr_addr = addr; bus.d_wr_addr_valid = v; end
        endcase
    endtask

    // Wait (bounded) for the channel's ready, pass the accepting edge, drop valid.
    task automatic wait_accept(input int ch, input string name);
        int n = 0;
        @(negedge clk);
        while (ready_of(ch) !== 1'b1 && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        check({name, "_accept"}, 96'(ready_of(ch)), 96'd1);
        tick();
        set_req(ch, 26'd0, 1'b0);
    endtask

    // Called just after the accepting edge: eight cycles, words at LAT..LAT+3.
    task automatic collect(input int ch, input line_t exp, input string name);
        for (int k = 0; k < 8; k++) begin
            logic        ev;
            logic [31:0] ew;
            logic [95:0] e;
            @(negedge clk);
            ev = (k >= LAT) && (k < LAT + 4);
            ew = ev ? exp[k - LAT] : 32'd0;
            if (ch == 0) e = {26'd0, ev, ew, 1'b0, 32'd0, 3'b000, 1'b0};
            else         e = {26'd0, 1'b0, 32'd0, ev, ew, 3'b000, 1'b0};
            check($sformatf("%s_k%0d", name, k), all_outs(), e);
            tick();
        end
    endtask

    // Called just after the accepting edge of a writeback.
    task automatic write_beats(input line_t words, input bit gapped, input string name);
        int beat = 0;
        int cyc  = 0;
        while (beat < 4 && cyc < 20) begin
            bus.d_wr_data_valid = gapped ? ((cyc % 2) == 0) : 1'b1;
            bus.d_wr_data       = words[beat];
            @(negedge clk);
            check($sformatf("%s_wrdy%0d", name, cyc), 96'(bus.d_wr_data_ready), 96'd1);
            tick();
            if (bus.d_wr_data_valid) beat++;
            cyc++;
        end
        bus.d_wr_data_valid = 1'b0;
        bus.d_wr_data       = 32'd0;
        @(negedge clk);
        check({name, "_wrdy_end"}, 96'(bus.d_wr_data_ready), 96'd0);
    endtask

    task automatic do_write(input logic [25:0] addr, input line_t words, input bit gapped,
                            input string name);
        tick();
        set_req(2, addr, 1'b1);
        wait_accept(2, name);
        write_beats(words, gapped, name);
    endtask

    task automatic do_read(input int ch, input logic [25:0] addr, input line_t exp,
                           input string name);
        tick();
        set_req(ch, addr, 1'b1);
        wait_accept(ch, name);
        collect(ch, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [8];
        line_t l_a, l_b, l_c, l_1, l_d, l_e;

        l_a = mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        l_b = mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        l_c = mk4(32'hC0C0_0000, 32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003);
        l_1 = mk4(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        l_d = mk4(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        l_e = mk4(32'hE000_00E0, 32'hE000_00E1, 32'hE000_00E2, 32'hE000_00E3);

        tbl[0] = '{op: 0, addr: 26'h0000100, gapped: 1'b0, words: l_a};
        tbl[1] = '{op: 1, addr: 26'h0000100, gapped: 1'b0, words: l_a};
        tbl[2] = '{op: 0, addr: 26'h0000200, gapped: 1'b0, words: l_1};
        tbl[3] = '{op: 2, addr: 26'h0000200, gapped: 1'b0, words: l_1};
        tbl[4] = '{op: 0, addr: 26'h0010100, gapped: 1'b0, words: l_b}; // aliases 0x100
        tbl[5] = '{op: 2, addr: 26'h000010C, gapped: 1'b0, words: l_b}; // offset ignored
        tbl[6] = '{op: 0, addr: 26'h003FFF0, gapped: 1'b1, words: l_c}; // top line, gapped
        tbl[7] = '{op: 1, addr: 26'h000FFF0, gapped: 1'b0, words: l_c};

        bus.i_rd_addr = '0; bus.i_rd_addr_valid = 1'b0;
        bus.d_rd_addr = '0; bus.d_rd_addr_valid = 1'b0;
        bus.d_wr_addr = '0; bus.d_wr_addr_valid = 1'b0;
        bus.d_wr_data = '0; bus.d_wr_data_valid = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), 96'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 96'd0);

        // Table-driven writes and reads
        for (int i = 0; i < 8; i++) begin
            case (tbl[i].op)
                0:       do_write(tbl[i].addr, tbl[i].words, tbl[i].gapped, $sformatf("vec%0d", i));
                1:       do_read(1, tbl[i].addr, tbl[i].words, $sformatf("vec%0d", i));
                default: do_read(0, tbl[i].addr, tbl[i].words, $sformatf("vec%0d", i));
            endcase
        end

        // Both readers at once: D first, I right after D's last word
        tick();
        set_req(0, 26'h0000200, 1'b1);
        set_req(1, 26'h0000100, 1'b1);
        @(negedge clk);
        check("prio_grant", 96'(readies()), 96'(3'b010));
        tick();
        set_req(1, 26'd0, 1'b0);
        collect(1, l_b, "prio_d");
        @(negedge clk);
        check("prio_i_next", 96'(readies()), 96'(3'b100));
        tick();
        set_req(0, 26'd0, 1'b0);
        collect(0, l_1, "prio_i");

        // All three at once: write, then D-read of the new data, then I-read
        tick();
        set_req(2, 26'h0000300, 1'b1);
        set_req(1, 26'h0000300, 1'b1);
        set_req(0, 26'h000FFF0, 1'b1);
        @(negedge clk);
        check("all3_grant", 96'(readies()), 96'(3'b001));
        tick();
        set_req(2, 26'd0, 1'b0);
        write_beats(l_e, 1'b0, "all3_w");
        check("all3_d_next", 96'(readies()), 96'(3'b010));
        tick();
        set_req(1, 26'd0, 1'b0);
        collect(1, l_e, "all3_d");
        @(negedge clk);
        check("all3_i_next", 96'(readies()), 96'(3'b100));
        tick();
        set_req(0, 26'd0, 1'b0);
        collect(0, l_c, "all3_i");

        // Gapped write, then readback; neighbour line untouched
        do_write(26'h0000400, l_d, 1'b1, "gap");
        do_read(1, 26'h0000400, l_d, "gap_rd");
        do_read(0, 26'h0000300, l_e, "gap_nbr");

        // Reset in the middle of a burst (beat 1 on the bus)
        tick();
        set_req(1, 26'h0000100, 1'b1);
        wait_accept(1, "rst_rd");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        check("rst_pre", all_outs(), {26'd0, 1'b0, 32'd0, 1'b1, 32'hB1, 4'b0000});
        rst = 1'b1;
        #1;
        check("rst_now", all_outs(), 96'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", k), all_outs(), 96'd0);
            tick();
        end
        do_read(1, 26'h0000100, l_b, "rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's three memory request channels: instruction-cache line read, data-cache line read, and data-cache line write. Arbitrates among them, serializes accesses to a single internal word-wide backing store, and returns or accepts cache lines as fixed-latency bursts. Sits at the top level between the core and main memory, as the responder end of the request protocol the caches initiate.

## Interface
Parameters:
- ADDR_W, 26: byte-address width.
- MEM_WORDS_LOG2, 14: log2 of backing store depth in 32-bit words.
- LINE_WORDS_LOG2, 2: log2 of words per cache line (burst length).
- LATENCY, 4: cycles from address acceptance to first read word; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_rd_addr  in  ADDR_W  I-cache line byte address.
- i_rd_addr_valid  in  1  I-cache read request.
- i_rd_addr_ready  out  1  I-cache request accepted this cycle.
- i_rd_data  out  32  I-cache burst word.
- i_rd_data_valid  out  1  i_rd_data holds a burst word.
- d_rd_addr, d_rd_addr_valid, d_rd_addr_ready, d_rd_data, d_rd_data_valid: same widths and directions as the i_rd_* ports, for the D-cache.
- d_wr_addr  in  ADDR_W  D-cache writeback line byte address.
- d_wr_addr_valid  in  1  writeback request.
- d_wr_addr_ready  out  1  writeback accepted this cycle.
- d_wr_data  in  32  writeback word.
- d_wr_data_valid  in  1  d_wr_data valid.
- d_wr_data_ready  out  1  responder accepts the write word this cycle.

## Operation
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST.
- IDLE: arbiter grants one asserted request; that channel's addr_ready is high combinationally. Handshake = valid & ready. Non-granted ready is low.
- Priority: d_wr > d_rd > i_rd (fixed; see Configuration).
- On accept: latch line base word index = addr[MEM_WORDS_LOG2+1 : LINE_WORDS_LOG2+2] (upper bits ignored and aliased; byte and word offsets ignored). Beat counter = 0.
- Read accept -> RD_WAIT, latency counter loaded with LATENCY-1; at 0 -> RD_BURST.
- RD_BURST: each cycle presents word {base, beat} on the granted channel with data_valid=1. No backpressure. After beat LINE_WORDS-1 -> IDLE.
- Write accept -> WR_BURST: d_wr_data_ready=1; each cycle with d_wr_data_valid writes word {base, beat} and increments beat; idle cycles insert no write. After LINE_WORDS writes -> IDLE.
- Non-granted data_valid and all data outputs are 0 when not valid.
- Accesses are strictly serialized, so a read accepted after a write to the same line returns the new data.
- Reset: outputs 0, FSM IDLE, counters 0, arbiter pointer to d_rd. Backing store contents are not cleared. An in-flight burst is abandoned with no further valid/ready.

## Timing
- Address accepted at edge T: read words on cycles T+LATENCY .. T+LATENCY+LINE_WORDS-1, one per cycle.
- Earliest next acceptance is the cycle after the last read word or last write beat. There are no back-to-back bursts with zero gap inside the same cycle.
- Write: d_wr_data_ready is high from cycle T+1 until the final beat is accepted. Minimum write occupancy is LINE_WORDS cycles.
- Simultaneous requests in IDLE: exactly one is granted. The others hold valid and are served later; the requester must hold valid and addr stable until ready.
- Read data outputs are registered. addr_ready is combinational from FSM state and valids.

## Configuration
- MEM_RESPONDER_RR_ARB_EN defined: d_wr keeps top priority. d_rd and i_rd alternate round-robin, with a last-served pointer updated on each read grant.
- Not defined: fixed priority d_wr > d_rd > i_rd; the pointer logic is absent.

## Structure
- Package mem_responder_pkg: state enum, grant enum (GNT_NONE, GNT_I_RD, GNT_D_RD, GNT_D_WR), word width 32, line-index slicing helper function.
- Sub-module mem_resp_arbiter: combinational grant from valids and the round-robin pointer, plus the pointer register. All other logic (FSM, counters, backing store array) lives in mem_responder.

## Test plan
- Write line at 0x100 with words 0xA0..0xA3, then read it via d_rd -> d_rd_data_valid on cycles T+4..T+7 with 0xA0,0xA1,0xA2,0xA3.
- i_rd and d_rd asserted together in IDLE, fixed priority -> d_rd granted first; i_rd granted the cycle after d_rd's last word.
- MEM_RESPONDER_RR_ARB_EN, both read channels held continuously for 4 bursts -> grants alternate d,i,d,i.
- d_wr, d_rd, i_rd all asserted simultaneously -> d_wr granted first, in either configuration.
- Write with d_wr_data_valid gapped (valid on alternate cycles) -> exactly 4 words stored; FSM returns to IDLE after the 4th.
- rst pulsed during RD_BURST at beat 1 -> all outputs 0 immediately; a read of the same line after reset returns the original data.
